// File: rtl/mem_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the requester not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an I-side and a D-side requester onto a single memory port.
// Build option MEM_ARB_TIMEOUT_EN bounds the memory wait to TIMEOUT_CYC cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             reqValid_REQ,
  input  logic [1:0][ADDR_W-1:0] reqAddress_REQ,
  input  logic [1:0][DATA_W-1:0] reqDataIn_REQ,
  input  logic [1:0]             reqWen_REQ,
  output logic [1:0]             respValid_REQ,
  output logic [DATA_W-1:0]      respDataOut_REQ,
  output logic                   reqValid_MEM,
  output logic [ADDR_W-1:0]      reqAddress_MEM,
  output logic [DATA_W-1:0]      reqDataOut_MEM,
  output logic                   reqWen_MEM,
  input  logic                   respValid_MEM,
  input  logic [DATA_W-1:0]      respDataIn_MEM,
  output logic                   busy,
  output logic                   timeout_err
);

  // state | meaning
  // IDLE  | no transaction; arbitrate among valid requesters
  // ISSUE | one-cycle memory request carrying the latched fields
  // WAIT  | waiting for respValid_MEM (or the timeout, when built in)
  // RESP  | one-cycle respValid_REQ to the granted requester

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          mask_q, mask_d;
  logic [1:0]          req_elig;
  logic                arb_valid;
  logic                arb_idx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`else
  // TIMEOUT_CYC has no effect without the timeout build.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  // The requester served in RESP still shows valid for one more cycle.
  assign req_elig = reqValid_REQ & ~mask_q;

  rr_arbiter2 u_rr (
    .req       (req_elig),
    .last      (last_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    data_d  = data_q;
    mask_d  = 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          last_d  = arb_idx;
          addr_d  = reqAddress_REQ[arb_idx];
          wdata_d = reqDataIn_REQ[arb_idx];
          wen_d   = reqWen_REQ[arb_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (respValid_MEM) begin
          data_d  = respDataIn_MEM;
          state_d = ST_RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          data_d  = DATA_W'(TIMEOUT_DATA);
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        mask_d  = last_q ? 2'b10 : 2'b01;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      mask_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign reqValid_MEM    = (state_q == ST_ISSUE);
  assign reqAddress_MEM  = addr_q;
  assign reqDataOut_MEM  = wdata_q;
  assign reqWen_MEM      = wen_q;
  assign respValid_REQ   = {(state_q == ST_RESP) &  last_q,
                            (state_q == ST_RESP) & ~last_q};
  assign respDataOut_REQ = data_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester/memory models, transaction-level checker.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          reqValid_REQ;
  logic [1:0][AW-1:0]  reqAddress_REQ;
  logic [1:0][DW-1:0]  reqDataIn_REQ;
  logic [1:0]          reqWen_REQ;
  logic [1:0]          respValid_REQ;
  logic [DW-1:0]       respDataOut_REQ;
  logic                reqValid_MEM;
  logic [AW-1:0]       reqAddress_MEM;
  logic [DW-1:0]       reqDataOut_MEM;
  logic                reqWen_MEM;
  logic                respValid_MEM;
  logic [DW-1:0]       respDataIn_MEM;
  logic                busy;
  logic                timeout_err;

  logic        rv[2];
  logic [31:0] ra[2];
  logic [31:0] rd[2];
  logic        rw[2];

  assign reqValid_REQ   = {rv[1], rv[0]};
  assign reqAddress_REQ = {ra[1], ra[0]};
  assign reqDataIn_REQ  = {rd[1], rd[0]};
  assign reqWen_REQ     = {rw[1], rw[0]};

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .reqValid_REQ    (reqValid_REQ),
    .reqAddress_REQ  (reqAddress_REQ),
    .reqDataIn_REQ   (reqDataIn_REQ),
    .reqWen_REQ      (reqWen_REQ),
    .respValid_REQ   (respValid_REQ),
    .respDataOut_REQ (respDataOut_REQ),
    .reqValid_MEM    (reqValid_MEM),
    .reqAddress_MEM  (reqAddress_MEM),
    .reqDataOut_MEM  (reqDataOut_MEM),
    .reqWen_MEM      (reqWen_MEM),
    .respValid_MEM   (respValid_MEM),
    .respDataIn_MEM  (respDataIn_MEM),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          start;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wen;
    bit          scramble;
    int          gap;
  } cmd_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          is_read;
    int          due;
  } exp_t;

  cmd_t        cmd_q[2][$];
  exp_t        exp_q[$];
  int          served_order[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat_mode = 1;   // 0: random 1..4, 1..4: fixed, 255: memory silent
  int          stray_req = 0;
  bit          req_busy[2];
  logic [31:0] tx_addr[2];
  logic [31:0] tx_data[2];
  logic        tx_wen[2];
  int          start_cyc[2];
  int          resp_cyc[2];
  int          resp_count[2];
  int          served_cnt[2];
  logic [31:0] last_mem_addr, last_mem_data, last_resp_data;
  logic        last_mem_wen;
  bit          exp_err = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic push_cmd(input int i, input int start, input logic [31:0] a,
                          input logic [31:0] d, input logic w, input bit scr, input int gap);
    cmd_t c;
    c.start = start; c.addr = a; c.data = d; c.wen = w; c.scramble = scr; c.gap = gap;
    cmd_q[i].push_back(c);
  endtask

  task automatic run_req(input int i);
    cmd_t c;
    int   t;
    int   sc;
    rv[i] = 1'b0; ra[i] = '0; rd[i] = '0; rw[i] = 1'b0;
    req_busy[i] = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst || cmd_q[i].size() == 0) continue;
      if (cyc < cmd_q[i][0].start) continue;
      c = cmd_q[i].pop_front();
      req_busy[i] = 1'b1;
      if (c.gap > 0) begin
        repeat (c.gap) @(posedge clk);
        #1;
      end
      tx_addr[i] = c.addr; tx_data[i] = c.data; tx_wen[i] = c.wen;
      ra[i] = c.addr; rd[i] = c.data; rw[i] = c.wen; rv[i] = 1'b1;
      start_cyc[i] = cyc;
      sc = served_cnt[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (!rst || respValid_REQ[i]) break;
        t++;
        if (t > 300) begin
          fail_now($sformatf("req%0d_wait", i));
          break;
        end
        if (c.scramble && served_cnt[i] != sc) begin
          ra[i] = $urandom; rd[i] = $urandom; rw[i] = 1'($urandom_range(0, 1));
        end
      end
      if (rst) begin
        @(posedge clk); #1;
      end
      rv[i] = 1'b0;
      req_busy[i] = 1'b0;
    end
  endtask

  initial run_req(0);
  initial run_req(1);

  // Memory slave: answers each request after the selected latency with mem_val(addr).
  initial begin : mem_model
    int          cnt;
    int          stray_done;
    logic [31:0] a;
    cnt = 0; stray_done = 0; a = '0;
    respValid_MEM = 1'b0; respDataIn_MEM = '0;
    forever begin
      @(posedge clk); #1;
      respValid_MEM = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          respValid_MEM  = 1'b1;
          respDataIn_MEM = mem_val(a);
        end
      end else if (stray_done != stray_req) begin
        stray_done++;
        respValid_MEM  = 1'b1;
        respDataIn_MEM = 32'h1234_5678;
      end
      if (reqValid_MEM) begin
        a   = reqAddress_MEM;
        cnt = (lat_mode == 255) ? 0 : (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
      end
    end
  end

  // Monitor: predicts the grant from sampled request valids and checks both ports.
  initial begin : monitor
    bit          outstanding;
    bit          last_served;
    bit          rd_l;
    bit          prev_mem;
    int          issue_cyc;
    int          win;
    logic [1:0]  prev_valid;
    logic [1:0]  oh;
    logic [31:0] addr_l;
    exp_t        e;
    outstanding = 0; last_served = 1; rd_l = 0; prev_mem = 0;
    issue_cyc = 0; win = 0; prev_valid = 2'b00; addr_l = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        outstanding = 0; last_served = 1; prev_valid = 2'b00; prev_mem = 0;
        exp_err = 1'b0;
        exp_q.delete();
        continue;
      end
      if (respValid_REQ != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", {62'd0, respValid_REQ}, 64'd0);
        end else begin
          e  = exp_q.pop_front();
          oh = (e.idx == 1) ? 2'b10 : 2'b01;
          chk("resp_strobe", {62'd0, respValid_REQ}, {62'd0, oh});
          chk("resp_cycle", cyc, e.due);
          if (e.is_read) chk("resp_data", respDataOut_REQ, e.data);
          chk("timeout_err", timeout_err, exp_err);
          last_resp_data = respDataOut_REQ;
          resp_cyc[e.idx] = cyc;
          resp_count[e.idx]++;
        end
      end
      if (outstanding && respValid_MEM) begin
        e.idx = win; e.data = mem_val(addr_l); e.is_read = rd_l; e.due = cyc + 1;
        exp_q.push_back(e);
        outstanding = 0;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (outstanding && cyc == issue_cyc + TO) begin
        e.idx = win; e.data = 32'hDEADBEEF; e.is_read = 1; e.due = cyc + 1;
        exp_q.push_back(e);
        exp_err = 1'b1;
        outstanding = 0;
      end
`endif
      if (reqValid_MEM) begin
        if (prev_mem) chk("mem_pulse_single", prev_mem, 1'b0);
        if (prev_valid == 2'b00) begin
          chk("mem_spurious", {63'd0, reqValid_MEM}, 64'd0);
        end else begin
          if (prev_valid == 2'b11) win = last_served ? 0 : 1;
          else                     win = prev_valid[1] ? 1 : 0;
          chk("mem_addr", reqAddress_MEM, tx_addr[win]);
          chk("mem_wen", reqWen_MEM, tx_wen[win]);
          if (tx_wen[win]) chk("mem_wdata", reqDataOut_MEM, tx_data[win]);
          last_mem_addr = reqAddress_MEM;
          last_mem_data = reqDataOut_MEM;
          last_mem_wen  = reqWen_MEM;
          last_served   = (win == 1);
          served_order.push_back(win);
          served_cnt[win]++;
          outstanding = 1; issue_cyc = cyc;
          addr_l = tx_addr[win]; rd_l = !tx_wen[win];
        end
      end
      prev_valid = reqValid_REQ;
      prev_mem   = reqValid_MEM;
    end
  end

  task automatic wait_idle(input int limit, input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((cmd_q[0].size() != 0 || cmd_q[1].size() != 0 || req_busy[0] || req_busy[1] ||
                busy || exp_q.size() != 0) && t < limit);
    if (t >= limit) fail_now(nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_respValid"}, {62'd0, respValid_REQ}, 64'd0);
    chk({nm, "_respData"}, respDataOut_REQ, 64'd0);
    chk({nm, "_reqValid_MEM"}, reqValid_MEM, 1'b0);
    chk({nm, "_reqAddress_MEM"}, reqAddress_MEM, 64'd0);
    chk({nm, "_reqDataOut_MEM"}, reqDataOut_MEM, 64'd0);
    chk({nm, "_reqWen_MEM"}, reqWen_MEM, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(nm);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sc;
    int t;
    int base;
    bit bad_busy, bad_resp, bad_mem;
    rst = 1'b0;
    lat_mode = 1;
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst = 1'b1;

    // Single read, memory latency 1.
    push_cmd(0, cyc + 2, 32'h100, 32'h0, 1'b0, 1'b0, 0);
    wait_idle(50, "t1_drain");
    chk("t1_latency", resp_cyc[0] - start_cyc[0], 3);
    chk("t1_mem_addr", last_mem_addr, 32'h100);
    chk("t1_issue_count", served_order.size(), 1);
    chk("t1_resp_count", resp_count[0], 1);

    // Stray memory response while idle.
    bad_busy = 0; bad_resp = 0;
    stray_req++;
    repeat (4) begin
      @(negedge clk);
      bad_busy |= busy;
      bad_resp |= (respValid_REQ != 2'b00);
    end
    chk("stray_busy", bad_busy, 1'b0);
    chk("stray_resp", bad_resp, 1'b0);

    // Simultaneous pair from reset: requester 0 first.
    do_reset("t2_rst");
    served_order.delete();
    push_cmd(0, cyc + 2, 32'h10, 32'h0, 1'b0, 1'b0, 0);
    push_cmd(1, cyc + 2, 32'h20, 32'h0, 1'b0, 1'b0, 0);
    wait_idle(60, "t2_drain");
    chk("t2_order_len", served_order.size(), 2);
    if (served_order.size() == 2) begin
      chk("t2_first", served_order[0], 0);
      chk("t2_second", served_order[1], 1);
    end

    // Requester 0 alone, then a pair: requester 1 wins this tie.
    served_order.delete();
    push_cmd(0, cyc + 2, 32'h14, 32'h0, 1'b0, 1'b0, 0);
    wait_idle(60, "t3a_drain");
    push_cmd(0, cyc + 2, 32'h18, 32'h0, 1'b0, 1'b0, 0);
    push_cmd(1, cyc + 2, 32'h24, 32'h0, 1'b0, 1'b0, 0);
    wait_idle(60, "t3b_drain");
    chk("t3_order_len", served_order.size(), 3);
    if (served_order.size() == 3) begin
      chk("t3_pair_first", served_order[1], 1);
      chk("t3_pair_second", served_order[2], 0);
    end

    // Write from requester 1 with inputs scrambled after the grant.
    lat_mode = 3;
    base = resp_count[1];
    push_cmd(1, cyc + 2, 32'h40, 32'hCAFE_F00D, 1'b1, 1'b1, 0);
    wait_idle(60, "t4_drain");
    chk("t4_mem_addr", last_mem_addr, 32'h40);
    chk("t4_mem_wen", last_mem_wen, 1'b1);
    chk("t4_mem_data", last_mem_data, 32'hCAFE_F00D);
    chk("t4_resp_pulses", resp_count[1] - base, 1);

    // Reset during WAIT, then a late memory response.
    lat_mode = 3;
    sc = served_cnt[0];
    push_cmd(0, cyc + 2, 32'h200, 32'h0, 1'b0, 1'b0, 0);
    t = 0;
    while (served_cnt[0] == sc && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (served_cnt[0] == sc) fail_now("t5_issue");
    do_reset("t5_rst");
    bad_busy = 0; bad_resp = 0; bad_mem = 0;
    repeat (6) begin
      @(negedge clk);
      bad_busy |= busy;
      bad_resp |= (respValid_REQ != 2'b00);
      bad_mem  |= reqValid_MEM;
    end
    chk("t5_busy", bad_busy, 1'b0);
    chk("t5_resp", bad_resp, 1'b0);
    chk("t5_mem_req", bad_mem, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: timeout response and sticky error.
    lat_mode = 255;
    push_cmd(0, cyc + 2, 32'h300, 32'h0, 1'b0, 1'b0, 0);
    wait_idle(80, "t6_drain");
    chk("t6_err_set", timeout_err, 1'b1);
    chk("t6_data", last_resp_data, 32'hDEADBEEF);
    lat_mode = 1;
    push_cmd(1, cyc + 2, 32'h304, 32'h0, 1'b0, 1'b0, 0);
    wait_idle(60, "t6b_drain");
    chk("t6_err_sticky", timeout_err, 1'b1);
    do_reset("t6_rst");
`endif

    // Random traffic from both requesters.
    lat_mode = 0;
    base = resp_count[0] + resp_count[1];
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 2; i++) begin
        push_cmd(i, 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
      end
    end
    wait_idle(5000, "rand_drain");
    chk("rand_resp_total", resp_count[0] + resp_count[1] - base, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
